// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: 4-digit BCD up/down counter advanced by a clock prescaler.
// Produces the packed BCD value for the display stage with update/wrap strobes.
module bcd_tick_counter #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned DIV_W    = 27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up_dn,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] bcd,
   output logic        update,
   output logic        wrap
);

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] presc_q, presc_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             update_q, update_d;
   logic             wrap_q, wrap_d;

   logic [15:0]      step_val;
   logic             step_wrap;
   logic [15:0]      sat_val;
   logic             step_edge;

   assign step_edge = en && (presc_q == PRESC_LAST);

   // Per-digit carry/borrow chain; a carry/borrow out of the top digit is a wrap.
   always_comb begin
      logic       c;
      logic [3:0] d;
      step_val = bcd_q;
      c        = 1'b1;
      d        = 4'd0;
      for (int i = 0; i < 4; i++) begin
         d = bcd_q[4*i +: 4];
         if (c) begin
            if (up_dn) begin
               if (d >= 4'd9) begin
                  d = 4'd0;
                  c = 1'b1;
               end else begin
                  d = d + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  d = 4'd9;
                  c = 1'b1;
               end else begin
                  d = d - 4'd1;
                  c = 1'b0;
               end
            end
         end
         step_val[4*i +: 4] = d;
      end
      step_wrap = c;
   end

   // Load value with each nibble saturated to 9 so the output stays valid BCD.
   always_comb begin
      sat_val = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         sat_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      end
   end

   // Next-state selection: clear > load > step > hold.
   always_comb begin
      presc_d  = presc_q;
      bcd_d    = bcd_q;
      update_d = 1'b0;
      wrap_d   = 1'b0;
      if (clear) begin
         presc_d  = '0;
         bcd_d    = 16'h0000;
         update_d = (bcd_q != 16'h0000);
      end else if (load) begin
         presc_d  = '0;
         bcd_d    = sat_val;
         update_d = 1'b1;
      end else if (step_edge) begin
         presc_d  = '0;
         bcd_d    = step_val;
         update_d = 1'b1;
         wrap_d   = step_wrap;
      end else if (en) begin
         presc_d  = presc_q + 1'b1;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         bcd_q    <= 16'h0000;
         update_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         bcd_q    <= bcd_d;
         update_q <= update_d;
         wrap_q   <= wrap_d;
      end
   end

   assign bcd    = bcd_q;
   assign update = update_q;
   assign wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed self-checking bench for bcd_tick_counter with TICK_DIV=4.
module tb_bcd_tick_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        up_dn;
   logic        clear;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] bcd;
   logic        update;
   logic        wrap;

   int checks   = 0;
   int failures = 0;

   bcd_tick_counter #(
      .TICK_DIV(4),
      .DIV_W   (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up_dn   (up_dn),
      .clear   (clear),
      .load    (load),
      .load_val(load_val),
      .bcd     (bcd),
      .update  (update),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Three quiet cycles then the step result; assumes prescaler is at 0.
   task automatic step_check(input string tag, input logic [15:0] exp_bcd, input logic exp_wrap);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({tag, "_quiet_upd"}, 16'(update), 16'h0);
      end
      tick();
      chk({tag, "_bcd"}, bcd, exp_bcd);
      chk({tag, "_upd"}, 16'(update), 16'h1);
      chk({tag, "_wrap"}, 16'(wrap), 16'(exp_wrap));
   endtask

   task automatic do_load(input string tag, input logic [15:0] val, input logic [15:0] exp);
      load     = 1'b1;
      load_val = val;
      tick();
      load = 1'b0;
      chk({tag, "_bcd"}, bcd, exp);
      chk({tag, "_upd"}, 16'(update), 16'h1);
      chk({tag, "_wrap"}, 16'(wrap), 16'h0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bcd", bcd, 16'h0000);
      chk("rst_upd", 16'(update), 16'h0);
      chk("rst_wrap", 16'(wrap), 16'h0);

      // First step after reset: TICK_DIV cycles, one-cycle update.
      rst = 1'b0; en = 1'b1; up_dn = 1'b1;
      step_check("first", 16'h0001, 1'b0);
      tick();
      chk("first_pulse_end", 16'(update), 16'h0);
      chk("first_hold", bcd, 16'h0001);

      // Decimal carry and up wrap.
      do_load("ld0999", 16'h0999, 16'h0999);
      step_check("carry", 16'h1000, 1'b0);
      do_load("ld9999", 16'h9999, 16'h9999);
      step_check("wrap_up", 16'h0000, 1'b1);

      // Borrow and down wrap.
      up_dn = 1'b0;
      do_load("ld1000", 16'h1000, 16'h1000);
      step_check("borrow", 16'h0999, 1'b0);
      do_load("ld0000", 16'h0000, 16'h0000);
      step_check("wrap_dn", 16'h9999, 1'b1);

      // Enable freeze keeps the partial period.
      up_dn = 1'b1;
      do_load("frz_ld", 16'h0000, 16'h0000);
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("frz_upd", 16'(update), 16'h0);
      end
      chk("frz_bcd", bcd, 16'h0000);
      en = 1'b1;
      tick();
      chk("frz_resume_quiet", 16'(update), 16'h0);
      tick();
      chk("frz_step_bcd", bcd, 16'h0001);
      chk("frz_step_upd", 16'(update), 16'h1);

      // Saturating load while disabled.
      en = 1'b0;
      do_load("sat", 16'hFA5B, 16'h9959);
      do_load("sat2", 16'h3A7F, 16'h3979);

      // clear + load + step edge together: clear wins, prescaler restarts.
      en = 1'b1;
      do_load("pri_ld", 16'h0500, 16'h0500);
      repeat (3) tick();
      clear = 1'b1; load = 1'b1; load_val = 16'h1234;
      tick();
      clear = 1'b0; load = 1'b0;
      chk("pri_clr_bcd", bcd, 16'h0000);
      chk("pri_clr_upd", 16'(update), 16'h1);
      chk("pri_clr_wrap", 16'(wrap), 16'h0);
      step_check("pri_restart", 16'h0001, 1'b0);

      // Load on a step edge discards the step.
      repeat (3) tick();
      do_load("ld_on_step", 16'h0042, 16'h0042);
      step_check("ld_restart", 16'h0043, 1'b0);

      // Clear of a zero value produces no update.
      en = 1'b0;
      clear = 1'b1;
      tick();
      chk("clr_nz_upd", 16'(update), 16'h1);
      tick();
      clear = 1'b0;
      chk("clr_z_upd", 16'(update), 16'h0);
      chk("clr_z_bcd", bcd, 16'h0000);

      // Asynchronous reset between edges.
      en = 1'b1;
      do_load("ar_ld", 16'h0357, 16'h0357);
      tick();
      chk("ar_pre_upd", 16'(update), 16'h0);
      #2 rst = 1'b1;
      #1;
      chk("ar_bcd", bcd, 16'h0000);
      chk("ar_upd", 16'(update), 16'h0);
      chk("ar_wrap", 16'(wrap), 16'h0);
      rst = 1'b0;
      step_check("ar_restart", 16'h0001, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
